reorder_buffer_gen: RTL and testbench

- Parametrised in-order-commit reorder buffer for the multi-lane MIPS pipeline; successor to the fixed 8-entry, 3-lane ROB.
- Fetch allocates one entry per cycle.
- NWB writeback lanes (ALU, load, slow/mult, ...) complete entries out of order.
- Head commits in order to the register bank or the store path; head exceptions flush the buffer.

---
 rtl/reorder_buffer_gen.sv | 215 +++++++++++++++++++++
 tb/tb_reorder_buffer_gen.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_gen.sv
// ---------------------------------------------------------------------------
// reorder_buffer_gen
//
// Parametrised in-order-commit reorder buffer for the multi-lane MIPS
// pipeline. Fetch allocates one entry per cycle at the tail, NWB writeback
// lanes complete entries out of order, and the head commits in order either
// to the register bank or to the store path. A head entry that carries an
// exception flushes the whole buffer.
//
// Parameters:
//   IDX_W - entry index width, DEPTH = 2**IDX_W entries
//   NWB   - number of writeback lanes
//   DW    - data / address / pc width
//   RW    - register selector width
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_alloc      fetch requests an entry this cycle
//   o_tail_out   index handed to the allocating instruction
//   o_stall      buffer full, allocation ignored
//   i_wb_valid   per-lane completion strobe
//   i_wb_idx     per-lane entry index   (lane i at [i*IDX_W +: IDX_W])
//   i_wb_pc      per-lane instruction pc (lane i at [i*DW +: DW])
//   i_wb_rd      per-lane destination register
//   i_wb_val     per-lane result or store data
//   i_wb_we      per-lane "writes a register"
//   i_wb_store   per-lane "is a store"
//   i_wb_addr    per-lane store address
//   i_wb_ex      per-lane "raised an exception"
//   o_we         register-bank write enable
//   o_rd_out     register-bank destination
//   o_val_out    register write data or store data
//   o_store_out  head is a completed store waiting for the store path
//   o_addr_out   store address
//   i_store_ack  store path accepted the store this cycle
//   o_exc        head committing with exception (one cycle)
//   o_exc_pc     pc of the head entry
//   o_count_out  number of occupied entries (0..DEPTH)
// ---------------------------------------------------------------------------
module reorder_buffer_gen #(
    parameter int IDX_W = 3,
    parameter int NWB   = 3,
    parameter int DW    = 32,
    parameter int RW    = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alloc,
    output logic [IDX_W-1:0]     o_tail_out,
    output logic                 o_stall,
    input  logic [NWB-1:0]       i_wb_valid,
    input  logic [NWB*IDX_W-1:0] i_wb_idx,
    input  logic [NWB*DW-1:0]    i_wb_pc,
    input  logic [NWB*RW-1:0]    i_wb_rd,
    input  logic [NWB*DW-1:0]    i_wb_val,
    input  logic [NWB-1:0]       i_wb_we,
    input  logic [NWB-1:0]       i_wb_store,
    input  logic [NWB*DW-1:0]    i_wb_addr,
    input  logic [NWB-1:0]       i_wb_ex,
    output logic                 o_we,
    output logic [RW-1:0]        o_rd_out,
    output logic [DW-1:0]        o_val_out,
    output logic                 o_store_out,
    output logic [DW-1:0]        o_addr_out,
    input  logic                 i_store_ack,
    output logic                 o_exc,
    output logic [DW-1:0]        o_exc_pc,
    output logic [IDX_W:0]       o_count_out
);

    localparam int             DEPTH = 1 << IDX_W;
    localparam logic [IDX_W:0] FULL  = (IDX_W+1)'(DEPTH);

    // Per-entry state
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_we;
    logic [DEPTH-1:0] r_store;
    logic [DEPTH-1:0] r_ex;
    logic [DW-1:0]    r_pc   [DEPTH];
    logic [DW-1:0]    r_val  [DEPTH];
    logic [DW-1:0]    r_addr [DEPTH];
    logic [RW-1:0]    r_rd   [DEPTH];

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    // Per-entry writeback selection
    logic [DEPTH-1:0] w_wb_hit;
    logic [DEPTH-1:0] w_wb_we;
    logic [DEPTH-1:0] w_wb_store;
    logic [DEPTH-1:0] w_wb_ex;
    logic [DW-1:0]    w_wb_pc   [DEPTH];
    logic [DW-1:0]    w_wb_val  [DEPTH];
    logic [DW-1:0]    w_wb_addr [DEPTH];
    logic [RW-1:0]    w_wb_rd   [DEPTH];

    // Head / control
    logic w_hv;
    logic w_exc;
    logic w_advance;
    logic w_accept;

    // For every entry, pick the writeback lane that targets it. Lanes are
    // scanned from the highest number down so the lowest-numbered matching
    // lane is the last assignment and wins a same-index collision. Entries
    // that are not currently allocated never take a writeback.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_wb_hit[e]   = 1'b0;
            w_wb_we[e]    = 1'b0;
            w_wb_store[e] = 1'b0;
            w_wb_ex[e]    = 1'b0;
            w_wb_pc[e]    = '0;
            w_wb_val[e]   = '0;
            w_wb_addr[e]  = '0;
            w_wb_rd[e]    = '0;
            for (int l = NWB - 1; l >= 0; l--) begin
                if (i_wb_valid[l] && r_valid[e] &&
                    (i_wb_idx[l*IDX_W +: IDX_W] == IDX_W'(e))) begin
                    w_wb_hit[e]   = 1'b1;
                    w_wb_we[e]    = i_wb_we[l];
                    w_wb_store[e] = i_wb_store[l];
                    w_wb_ex[e]    = i_wb_ex[l];
                    w_wb_pc[e]    = i_wb_pc[l*DW +: DW];
                    w_wb_val[e]   = i_wb_val[l*DW +: DW];
                    w_wb_addr[e]  = i_wb_addr[l*DW +: DW];
                    w_wb_rd[e]    = i_wb_rd[l*RW +: RW];
                end
            end
        end
    end

    // The head is committable once it is both allocated and completed. An
    // exception at the head takes priority over any advance; a store only
    // leaves the head once the store path has acknowledged it. Allocation
    // looks only at the registered count, so a commit in the same cycle
    // cannot free a slot for it.
    assign w_hv      = r_valid[r_head] & r_done[r_head];
    assign w_exc     = w_hv & r_ex[r_head];
    assign w_advance = w_hv & ~r_ex[r_head] & (~r_store[r_head] | i_store_ack);
    assign w_accept  = i_alloc & ~o_stall;

    assign o_stall     = (r_count == FULL);
    assign o_tail_out  = r_tail;
    assign o_count_out = r_count;

    // Commit-side outputs are driven straight from the head entry and are
    // forced to zero whenever the head is not committable, so an empty or
    // waiting buffer presents a quiet interface.
    assign o_exc       = w_exc;
    assign o_exc_pc    = w_hv ? r_pc[r_head]   : '0;
    assign o_we        = w_hv & r_we[r_head] & ~r_ex[r_head] & ~r_store[r_head];
    assign o_store_out = w_hv & r_store[r_head] & ~r_ex[r_head];
    assign o_rd_out    = w_hv ? r_rd[r_head]   : '0;
    assign o_val_out   = w_hv ? r_val[r_head]  : '0;
    assign o_addr_out  = w_hv ? r_addr[r_head] : '0;

    // Main state update. An exception at the head wipes the buffer and
    // discards everything else arriving in that cycle. Otherwise the order
    // of the statements matters: writebacks are applied first, then the
    // tail allocation, then the head retirement, so that a retiring entry
    // is always left invalid even if a lane wrote it in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_done  <= '0;
            r_we    <= '0;
            r_store <= '0;
            r_ex    <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_pc[e]   <= '0;
                r_val[e]  <= '0;
                r_addr[e] <= '0;
                r_rd[e]   <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_exc) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_wb_hit[e]) begin
                    r_done[e]  <= 1'b1;
                    r_we[e]    <= w_wb_we[e];
                    r_store[e] <= w_wb_store[e];
                    r_ex[e]    <= w_wb_ex[e];
                    r_pc[e]    <= w_wb_pc[e];
                    r_val[e]   <= w_wb_val[e];
                    r_addr[e]  <= w_wb_addr[e];
                    r_rd[e]    <= w_wb_rd[e];
                end
            end
            if (w_accept) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + IDX_W'(1);
            end
            if (w_advance) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
            end
            r_count <= r_count + (IDX_W+1)'(w_accept) - (IDX_W+1)'(w_advance);
        end
    end

endmodule

// File: tb/tb_reorder_buffer_gen.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer_gen
//
// Self-checking bench for reorder_buffer_gen (IDX_W=3, NWB=3, DW=32, RW=5).
// Directed scenarios exercise fill/stall, out-of-order completion, store
// back-pressure, exception flush, full-buffer wrap and asynchronous reset;
// a randomized run then compares every output against a queue-based model
// of the buffer kept in program order.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reorder_buffer_gen;

    localparam int IDX_W = 3;
    localparam int NWB   = 3;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rstN = 1'b0;
    logic                 alloc;
    logic [IDX_W-1:0]     tailOut;
    logic                 stall;
    logic [NWB-1:0]       wbValid;
    logic [NWB*IDX_W-1:0] wbIdx;
    logic [NWB*DW-1:0]    wbPc;
    logic [NWB*RW-1:0]    wbRd;
    logic [NWB*DW-1:0]    wbVal;
    logic [NWB-1:0]       wbWe;
    logic [NWB-1:0]       wbStore;
    logic [NWB*DW-1:0]    wbAddr;
    logic [NWB-1:0]       wbEx;
    logic                 we;
    logic [RW-1:0]        rdOut;
    logic [DW-1:0]        valOut;
    logic                 storeOut;
    logic [DW-1:0]        addrOut;
    logic                 storeAck;
    logic                 exc;
    logic [DW-1:0]        excPc;
    logic [IDX_W:0]       countOut;

    int nChecks = 0;
    int nFails  = 0;

    reorder_buffer_gen #(
        .IDX_W(IDX_W), .NWB(NWB), .DW(DW), .RW(RW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_alloc    (alloc),
        .o_tail_out (tailOut),
        .o_stall    (stall),
        .i_wb_valid (wbValid),
        .i_wb_idx   (wbIdx),
        .i_wb_pc    (wbPc),
        .i_wb_rd    (wbRd),
        .i_wb_val   (wbVal),
        .i_wb_we    (wbWe),
        .i_wb_store (wbStore),
        .i_wb_addr  (wbAddr),
        .i_wb_ex    (wbEx),
        .o_we       (we),
        .o_rd_out   (rdOut),
        .o_val_out  (valOut),
        .o_store_out(storeOut),
        .o_addr_out (addrOut),
        .i_store_ack(storeAck),
        .o_exc      (exc),
        .o_exc_pc   (excPc),
        .o_count_out(countOut)
    );

    always #5 clk = ~clk;

    // Reference model: entries live in a program-ordered queue of indices;
    // the front of the queue is the head. Occupancy is the queue size.
    typedef struct {
        bit              done;
        bit              we;
        bit              store;
        bit              ex;
        logic [DW-1:0]   pc;
        logic [DW-1:0]   val;
        logic [DW-1:0]   addr;
        logic [RW-1:0]   rd;
    } ent_t;

    ent_t mEnt [DEPTH];
    int   mOrder[$];
    int   mTail;

    logic [IDX_W:0]   eCount;
    logic [IDX_W-1:0] eTail;
    logic             eStall, eHv, eExc, eWe, eStore;
    logic [RW-1:0]    eRd;
    logic [DW-1:0]    eVal, eAddr, eExcPc;

    function automatic void modelReset();
        mOrder.delete();
        mTail = 0;
        for (int e = 0; e < DEPTH; e++) mEnt[e].done = 1'b0;
    endfunction

    function automatic bit modelInQueue(int idx);
        foreach (mOrder[k]) if (mOrder[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void modelOutputs();
        int h;
        h      = (mOrder.size() > 0) ? mOrder[0] : 0;
        eHv    = (mOrder.size() > 0) && mEnt[h].done;
        eCount = (IDX_W+1)'(mOrder.size());
        eStall = (mOrder.size() == DEPTH);
        eTail  = IDX_W'(mTail);
        eExc   = eHv && mEnt[h].ex;
        eWe    = eHv && mEnt[h].we && !mEnt[h].ex && !mEnt[h].store;
        eStore = eHv && mEnt[h].store && !mEnt[h].ex;
        eRd    = eHv ? mEnt[h].rd   : '0;
        eVal   = eHv ? mEnt[h].val  : '0;
        eAddr  = eHv ? mEnt[h].addr : '0;
        eExcPc = eHv ? mEnt[h].pc   : '0;
    endfunction

    // One clock edge of the model, using the inputs currently driven.
    function automatic void modelUpdate();
        int h;
        bit hv, adv, full;
        bit claimed [DEPTH];
        for (int e = 0; e < DEPTH; e++) claimed[e] = 1'b0;
        h  = (mOrder.size() > 0) ? mOrder[0] : 0;
        hv = (mOrder.size() > 0) && mEnt[h].done;
        if (hv && mEnt[h].ex) begin
            mOrder.delete();
            mTail = 0;
            return;
        end
        adv  = hv && (!mEnt[h].store || storeAck);
        full = (mOrder.size() == DEPTH);
        for (int l = 0; l < NWB; l++) begin
            int idx;
            idx = int'(wbIdx[l*IDX_W +: IDX_W]);
            if (wbValid[l] && modelInQueue(idx) && !claimed[idx]) begin
                claimed[idx]    = 1'b1;
                mEnt[idx].done  = 1'b1;
                mEnt[idx].we    = wbWe[l];
                mEnt[idx].store = wbStore[l];
                mEnt[idx].ex    = wbEx[l];
                mEnt[idx].pc    = wbPc[l*DW +: DW];
                mEnt[idx].val   = wbVal[l*DW +: DW];
                mEnt[idx].addr  = wbAddr[l*DW +: DW];
                mEnt[idx].rd    = wbRd[l*RW +: RW];
            end
        end
        if (alloc && !full) begin
            mEnt[mTail].done = 1'b0;
            mOrder.push_back(mTail);
            mTail = (mTail + 1) % DEPTH;
        end
        if (adv) void'(mOrder.pop_front());
    endfunction

    task automatic idleInputs();
        alloc    = 1'b0;
        wbValid  = '0;
        wbIdx    = '0;
        wbPc     = '0;
        wbRd     = '0;
        wbVal    = '0;
        wbWe     = '0;
        wbStore  = '0;
        wbAddr   = '0;
        wbEx     = '0;
        storeAck = 1'b0;
    endtask

    task automatic setLane(input int l, input int idx, input logic [DW-1:0] pc,
                           input logic [RW-1:0] rd, input logic [DW-1:0] val,
                           input bit lwe, input bit lst, input logic [DW-1:0] addr,
                           input bit lex);
        wbValid[l]              = 1'b1;
        wbIdx[l*IDX_W +: IDX_W] = IDX_W'(idx);
        wbPc[l*DW +: DW]        = pc;
        wbRd[l*RW +: RW]        = rd;
        wbVal[l*DW +: DW]       = val;
        wbWe[l]                 = lwe;
        wbStore[l]              = lst;
        wbAddr[l*DW +: DW]      = addr;
        wbEx[l]                 = lex;
    endtask

    // Advance one clock edge; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic doReset();
        idleInputs();
        rstN = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idleInputs();
        rstN = 1'b0;
        modelReset();
        #2;
        nChecks++;
        if (countOut !== '0 || tailOut !== '0 || stall !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_state: count=%0d tail=%0d stall=%0b expected 0/0/0", countOut, tailOut, stall);
        end
        nChecks++;
        if ({we, storeOut, exc} !== 3'b000 || rdOut !== '0 || valOut !== '0 || addrOut !== '0 || excPc !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: we=%0b store=%0b exc=%0b rd=%0d val=%h addr=%h pc=%h expected all 0",
                     we, storeOut, exc, rdOut, valOut, addrOut, excPc);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        doReset();
        alloc = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            nChecks++;
            if (tailOut !== IDX_W'(i)) begin
                nFails++;
                $display("[TB] FAIL fill_tail: got %0d expected %0d", tailOut, i);
            end
            step();
        end
        nChecks++;
        if (countOut !== 4'd8 || stall !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL fill_full: count=%0d stall=%0b expected 8/1", countOut, stall);
        end
        step();
        alloc = 1'b0;
        nChecks++;
        if (countOut !== 4'd8 || tailOut !== 3'd0) begin
            nFails++;
            $display("[TB] FAIL fill_ninth_ignored: count=%0d tail=%0d expected 8/0", countOut, tailOut);
        end
    endtask

    task automatic test_out_of_order();
        doReset();
        alloc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        alloc = 1'b0;
        setLane(2, 2, 32'h8, 5'd3, 32'h30, 1'b1, 1'b0, '0, 1'b0);
        step();
        idleInputs();
        nChecks++;
        if (we !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ooo_no_early_commit: we=%0b expected 0", we);
        end
        step();
        nChecks++;
        if (we !== 1'b0 || countOut !== 4'd3) begin
            nFails++;
            $display("[TB] FAIL ooo_still_waiting: we=%0b count=%0d expected 0/3", we, countOut);
        end
        setLane(0, 0, 32'h0, 5'd1, 32'h10, 1'b1, 1'b0, '0, 1'b0);
        step();
        idleInputs();
        nChecks++;
        if (we !== 1'b1 || rdOut !== 5'd1 || valOut !== 32'h10) begin
            nFails++;
            $display("[TB] FAIL ooo_commit0: we=%0b rd=%0d val=%h expected 1/1/10", we, rdOut, valOut);
        end
        setLane(1, 1, 32'h4, 5'd2, 32'h20, 1'b1, 1'b0, '0, 1'b0);
        step();
        idleInputs();
        nChecks++;
        if (we !== 1'b1 || rdOut !== 5'd2 || valOut !== 32'h20) begin
            nFails++;
            $display("[TB] FAIL ooo_commit1: we=%0b rd=%0d val=%h expected 1/2/20", we, rdOut, valOut);
        end
        step();
        nChecks++;
        if (we !== 1'b1 || rdOut !== 5'd3 || valOut !== 32'h30) begin
            nFails++;
            $display("[TB] FAIL ooo_commit2: we=%0b rd=%0d val=%h expected 1/3/30", we, rdOut, valOut);
        end
        step();
        nChecks++;
        if (we !== 1'b0 || countOut !== 4'd0) begin
            nFails++;
            $display("[TB] FAIL ooo_drained: we=%0b count=%0d expected 0/0", we, countOut);
        end
    endtask

    task automatic test_store();
        doReset();
        alloc = 1'b1;
        step();
        alloc = 1'b0;
        setLane(0, 0, 32'h50, 5'd0, 32'hAB, 1'b0, 1'b1, 32'h100, 1'b0);
        step();
        idleInputs();
        for (int c = 0; c < 3; c++) begin
            nChecks++;
            if (storeOut !== 1'b1 || addrOut !== 32'h100 || valOut !== 32'hAB || we !== 1'b0 || countOut !== 4'd1) begin
                nFails++;
                $display("[TB] FAIL store_hold%0d: store=%0b addr=%h val=%h we=%0b count=%0d expected 1/100/ab/0/1",
                         c, storeOut, addrOut, valOut, we, countOut);
            end
            if (c < 2) step();
        end
        storeAck = 1'b1;
        step();
        storeAck = 1'b0;
        nChecks++;
        if (storeOut !== 1'b0 || countOut !== 4'd0 || we !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL store_acked: store=%0b count=%0d we=%0b expected 0/0/0", storeOut, countOut, we);
        end
    endtask

    task automatic test_exception();
        doReset();
        alloc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        alloc = 1'b0;
        setLane(0, 0, 32'h40, 5'd4, 32'h11, 1'b1, 1'b0, '0, 1'b0);
        step();
        idleInputs();
        nChecks++;
        if (we !== 1'b1 || rdOut !== 5'd4 || exc !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL exc_pre_commit: we=%0b rd=%0d exc=%0b expected 1/4/0", we, rdOut, exc);
        end
        setLane(1, 1, 32'h44, 5'd5, 32'h22, 1'b1, 1'b0, '0, 1'b1);
        step();
        idleInputs();
        nChecks++;
        if (exc !== 1'b1 || excPc !== 32'h44 || we !== 1'b0 || countOut !== 4'd3) begin
            nFails++;
            $display("[TB] FAIL exc_raise: exc=%0b pc=%h we=%0b count=%0d expected 1/44/0/3", exc, excPc, we, countOut);
        end
        alloc = 1'b1;
        setLane(0, 2, 32'h48, 5'd6, 32'h33, 1'b1, 1'b0, '0, 1'b0);
        step();
        idleInputs();
        nChecks++;
        if (exc !== 1'b0 || countOut !== 4'd0 || tailOut !== 3'd0 || we !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL exc_flush: exc=%0b count=%0d tail=%0d we=%0b expected 0/0/0/0", exc, countOut, tailOut, we);
        end
        alloc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        alloc = 1'b0;
        setLane(0, 0, 32'h60, 5'd8, 32'h80, 1'b1, 1'b0, '0, 1'b0);
        setLane(1, 1, 32'h64, 5'd9, 32'h90, 1'b1, 1'b0, '0, 1'b0);
        step();
        idleInputs();
        step();
        step();
        nChecks++;
        if (we !== 1'b0 || countOut !== 4'd1) begin
            nFails++;
            $display("[TB] FAIL exc_discarded_wb: we=%0b count=%0d expected 0/1", we, countOut);
        end
    endtask

    task automatic test_full_wrap();
        doReset();
        alloc = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        alloc = 1'b0;
        setLane(0, 0, 32'h70, 5'd10, 32'h77, 1'b1, 1'b0, '0, 1'b0);
        step();
        idleInputs();
        nChecks++;
        if (we !== 1'b1 || stall !== 1'b1 || countOut !== 4'd8) begin
            nFails++;
            $display("[TB] FAIL wrap_head_ready: we=%0b stall=%0b count=%0d expected 1/1/8", we, stall, countOut);
        end
        alloc = 1'b1;
        step();
        alloc = 1'b0;
        nChecks++;
        if (countOut !== 4'd7 || stall !== 1'b0 || tailOut !== 3'd0) begin
            nFails++;
            $display("[TB] FAIL wrap_alloc_rejected: count=%0d stall=%0b tail=%0d expected 7/0/0", countOut, stall, tailOut);
        end
        alloc = 1'b1;
        step();
        alloc = 1'b0;
        nChecks++;
        if (countOut !== 4'd8 || tailOut !== 3'd1) begin
            nFails++;
            $display("[TB] FAIL wrap_alloc_idx0: count=%0d tail=%0d expected 8/1", countOut, tailOut);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        alloc = 1'b1;
        for (int i = 0; i < 5; i++) step();
        alloc = 1'b0;
        setLane(0, 0, 32'h90, 5'd11, 32'h99, 1'b1, 1'b0, '0, 1'b0);
        step();
        idleInputs();
        nChecks++;
        if (we !== 1'b1 || countOut !== 4'd5) begin
            nFails++;
            $display("[TB] FAIL areset_pre: we=%0b count=%0d expected 1/5", we, countOut);
        end
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        nChecks++;
        if (we !== 1'b0 || rdOut !== '0 || valOut !== '0 || countOut !== '0 || tailOut !== '0 || stall !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL areset_immediate: we=%0b rd=%0d val=%h count=%0d tail=%0d stall=%0b expected all 0",
                     we, rdOut, valOut, countOut, tailOut, stall);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        alloc = 1'b1;
        nChecks++;
        if (tailOut !== 3'd0) begin
            nFails++;
            $display("[TB] FAIL areset_first_tail: got %0d expected 0", tailOut);
        end
        step();
        alloc = 1'b0;
        nChecks++;
        if (tailOut !== 3'd1 || countOut !== 4'd1) begin
            nFails++;
            $display("[TB] FAIL areset_first_alloc: tail=%0d count=%0d expected 1/1", tailOut, countOut);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            modelOutputs();
            nChecks++;
            if (countOut !== eCount || tailOut !== eTail || stall !== eStall) begin
                nFails++;
                $display("[TB] FAIL rand_occupancy cyc %0d: count=%0d tail=%0d stall=%0b expected %0d/%0d/%0b",
                         cyc, countOut, tailOut, stall, eCount, eTail, eStall);
            end
            nChecks++;
            if ({we, storeOut, exc} !== {eWe, eStore, eExc}) begin
                nFails++;
                $display("[TB] FAIL rand_strobes cyc %0d: we/store/exc=%b expected %b",
                         cyc, {we, storeOut, exc}, {eWe, eStore, eExc});
            end
            nChecks++;
            if (rdOut !== eRd || valOut !== eVal || addrOut !== eAddr) begin
                nFails++;
                $display("[TB] FAIL rand_data cyc %0d: rd=%0d val=%h addr=%h expected %0d/%h/%h",
                         cyc, rdOut, valOut, addrOut, eRd, eVal, eAddr);
            end
            if (eExc || !eHv) begin
                nChecks++;
                if (excPc !== eExcPc) begin
                    nFails++;
                    $display("[TB] FAIL rand_exc_pc cyc %0d: got %h expected %h", cyc, excPc, eExcPc);
                end
            end
            idleInputs();
            alloc    = ($urandom_range(0, 9) < 6);
            storeAck = 1'($urandom_range(0, 1));
            for (int l = 0; l < NWB; l++) begin
                int idx;
                if ($urandom_range(0, 9) < 4) begin
                    if (mOrder.size() > 0 && $urandom_range(0, 9) < 8)
                        idx = mOrder[$urandom_range(0, mOrder.size() - 1)];
                    else
                        idx = $urandom_range(0, DEPTH - 1);
                    setLane(l, idx, $urandom, RW'($urandom_range(0, 31)), $urandom,
                            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                            $urandom, ($urandom_range(0, 39) == 0));
                end
            end
            step();
        end
        idleInputs();
    endtask

    initial begin
        $display("[TB] reorder_buffer_gen bench start");
        test_reset();
        test_fill();
        test_out_of_order();
        test_store();
        test_exception();
        test_full_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
